// File: rtl/ep0_ctrl_handler.sv
// Endpoint-0 control-transfer engine: decodes standard SETUP requests, sequences
// data/status stages and feeds descriptor-ROM chunk requests to the packetiser.
module ep0_ctrl_handler #(
   parameter int MAX_PKT       = 8,
   parameter int ROM_AW        = 8,
   parameter int DEV_DESC_ADDR = 0,
   parameter int DEV_DESC_LEN  = 18,
   parameter int CFG_DESC_ADDR = 18,
   parameter int CFG_DESC_LEN  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              setup_valid,
   input  logic              bmRequestTypeDPTD,
   input  logic [1:0]        bmRequestTypeType,
   input  logic [4:0]        bmRequestTypeRecipient,
   input  logic [7:0]        bRequest,
   input  logic [15:0]       wValue,
   input  logic [15:0]       wIndex,
   input  logic [15:0]       wLength,
   input  logic              in_token,
   input  logic              out_token,
   input  logic              out_zlp,
   input  logic              tx_ack,
   output logic              tx_req,
   output logic [ROM_AW-1:0] tx_addr,
   output logic [6:0]        tx_len,
   output logic              tx_zero,
   output logic              tx_data1,
   output logic              stall,
   output logic [6:0]        dev_addr,
   output logic              configured
);

   typedef enum logic [2:0] {
      IDLE, DECODE, DATA_IN, WAIT_ACK, STATUS_OUT, STATUS_IN, STATUS_WAIT, STALL
   } state_t;

   localparam logic [15:0] PKT16 = 16'(MAX_PKT);

   function automatic logic [15:0] min16(input logic [15:0] a, input logic [15:0] b);
      return (a < b) ? a : b;
   endfunction

   state_t state, nextState;

   logic              reqDir;
   logic [1:0]        reqType;
   logic [7:0]        reqCode;
   logic [15:0]       reqValue;
   logic [15:0]       reqLength;

   logic [ROM_AW-1:0] ptr;
   logic [15:0]       remaining;
   logic              needZlp, toggle, srcZero;
   logic [6:0]        pendAddr;
   logic              pendAddrVld, pendCfg, pendCfgVld;

   logic              isStd, descDev, descCfg, getDescOk, isGetStatus, isSetAddr, isSetCfg;
   logic              decodeOk, hasData;
   logic [15:0]       descLen;
   logic [ROM_AW-1:0] descBase;
   logic [15:0]       remAfterAck;
   logic              moreToSend, moreAfterAck;
   logic [6:0]        chunk;
   logic              loadDecode, issueData, retry, issueZlp, advance, commit;

   logic              unusedInputs;
   assign unusedInputs = ^{wIndex, bmRequestTypeRecipient};

   // SETUP fields are only guaranteed stable on the strobe, so hold them for DECODE
   always_ff @(posedge clk) begin
      if (setup_valid) begin
         reqDir    <= bmRequestTypeDPTD;
         reqType   <= bmRequestTypeType;
         reqCode   <= bRequest;
         reqValue  <= wValue;
         reqLength <= wLength;
      end
   end

   always_comb begin
      isStd       = (reqType == 2'd0);
      descDev     = (reqValue[15:8] == 8'd1);
      descCfg     = (reqValue[15:8] == 8'd2);
      getDescOk   = isStd && reqDir && (reqCode == 8'h06) && (descDev || descCfg);
      isGetStatus = isStd && reqDir && (reqCode == 8'h00);
      isSetAddr   = isStd && !reqDir && (reqCode == 8'h05) && (reqValue <= 16'd127);
      isSetCfg    = isStd && !reqDir && (reqCode == 8'h09) && (reqValue[7:0] <= 8'd1);
      decodeOk    = getDescOk || isGetStatus || isSetAddr || isSetCfg;
      hasData     = (getDescOk || isGetStatus) && (reqLength != 16'd0);
      descLen     = descDev ? 16'(DEV_DESC_LEN) : 16'(CFG_DESC_LEN);
      descBase    = descDev ? ROM_AW'(DEV_DESC_ADDR) : ROM_AW'(CFG_DESC_ADDR);
      moreToSend  = (remaining != 16'd0) || needZlp;
      remAfterAck = remaining - 16'(tx_len);
      moreAfterAck = (remAfterAck != 16'd0) || (needZlp && (tx_len != 7'd0));
      chunk       = (remaining > PKT16) ? 7'(MAX_PKT) : remaining[6:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= nextState;
   end

   always_comb begin
      nextState = state;
      if (setup_valid) nextState = DECODE;
      else begin
         case (state)
            DECODE:      nextState = !decodeOk ? STALL : (hasData ? DATA_IN : STATUS_IN);
            DATA_IN:     if (out_token) nextState = STATUS_OUT;
                         else if (in_token) nextState = moreToSend ? WAIT_ACK : STATUS_OUT;
            WAIT_ACK:    if (out_token) nextState = STATUS_OUT;
                         else if (tx_ack) nextState = moreAfterAck ? DATA_IN : STATUS_OUT;
            STATUS_OUT:  if (out_zlp) nextState = IDLE;
            STATUS_IN:   if (in_token) nextState = STATUS_WAIT;
            STATUS_WAIT: if (tx_ack) nextState = IDLE;
            default:     nextState = state;
         endcase
      end
   end

   always_comb begin
      stall      = (state == STALL);
      loadDecode = !setup_valid && (state == DECODE);
      issueData  = !setup_valid && (state == DATA_IN) && in_token && !out_token && moreToSend;
      retry      = !setup_valid && in_token && !tx_ack &&
                   (((state == WAIT_ACK) && !out_token) || (state == STATUS_WAIT));
      issueZlp   = !setup_valid && (state == STATUS_IN) && in_token;
      advance    = !setup_valid && (state == WAIT_ACK) && tx_ack && !out_token;
      commit     = !setup_valid && (state == STATUS_WAIT) && tx_ack;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_req      <= 1'b0;
         tx_addr     <= '0;
         tx_len      <= '0;
         tx_zero     <= 1'b0;
         tx_data1    <= 1'b0;
         dev_addr    <= '0;
         configured  <= 1'b0;
         ptr         <= '0;
         remaining   <= '0;
         needZlp     <= 1'b0;
         toggle      <= 1'b0;
         srcZero     <= 1'b0;
         pendAddr    <= '0;
         pendAddrVld <= 1'b0;
         pendCfg     <= 1'b0;
         pendCfgVld  <= 1'b0;
      end else begin
         tx_req <= 1'b0;
         if (setup_valid) begin
            toggle      <= 1'b1;
            pendAddrVld <= 1'b0;
            pendCfgVld  <= 1'b0;
         end
         if (loadDecode) begin
            needZlp <= 1'b0;
            srcZero <= 1'b0;
            if (getDescOk) begin
               remaining <= min16(reqLength, descLen);
               ptr       <= descBase;
               needZlp   <= (descLen < reqLength) && ((descLen % PKT16) == 16'd0);
            end
            if (isGetStatus) begin
               remaining <= min16(reqLength, 16'd2);
               srcZero   <= 1'b1;
            end
            if (isSetAddr) begin
               pendAddr    <= reqValue[6:0];
               pendAddrVld <= 1'b1;
            end
            if (isSetCfg) begin
               pendCfg    <= reqValue[0];
               pendCfgVld <= 1'b1;
            end
         end
         if (issueData) begin
            tx_req   <= 1'b1;
            tx_addr  <= ptr;
            tx_len   <= chunk;
            tx_data1 <= toggle;
            tx_zero  <= srcZero;
         end
         // Retries re-send the held descriptor untouched, so PID and chunk stay identical
         if (retry) tx_req <= 1'b1;
         if (issueZlp) begin
            tx_req   <= 1'b1;
            tx_addr  <= ptr;
            tx_len   <= 7'd0;
            tx_data1 <= 1'b1;
            tx_zero  <= 1'b0;
         end
         if (advance) begin
            ptr       <= ptr + ROM_AW'(tx_len);
            remaining <= remAfterAck;
            toggle    <= ~toggle;
            if (tx_len == 7'd0) needZlp <= 1'b0;
         end
         // Address and configuration only take effect once the status stage is acked
         if (commit) begin
            if (pendAddrVld) dev_addr <= pendAddr;
            if (pendCfgVld) configured <= pendCfg;
            pendAddrVld <= 1'b0;
            pendCfgVld  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ep0_ctrl_handler.sv
// Directed bench for ep0_ctrl_handler with hand-computed packet sequences.
module tb_ep0_ctrl_handler;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       setup_valid = 1'b0;
   logic       bmRequestTypeDPTD = 1'b0;
   logic [1:0] bmRequestTypeType = 2'd0;
   logic [4:0] bmRequestTypeRecipient = 5'd0;
   logic [7:0] bRequest = 8'd0;
   logic [15:0] wValue = 16'd0;
   logic [15:0] wIndex = 16'd0;
   logic [15:0] wLength = 16'd0;
   logic       in_token = 1'b0;
   logic       out_token = 1'b0;
   logic       out_zlp = 1'b0;
   logic       tx_ack = 1'b0;
   logic       tx_req;
   logic [7:0] tx_addr;
   logic [6:0] tx_len;
   logic       tx_zero;
   logic       tx_data1;
   logic       stall;
   logic [6:0] dev_addr;
   logic       configured;

   int checks = 0;
   int failures = 0;

   ep0_ctrl_handler dut (
      .clk(clk), .reset(reset), .setup_valid(setup_valid),
      .bmRequestTypeDPTD(bmRequestTypeDPTD), .bmRequestTypeType(bmRequestTypeType),
      .bmRequestTypeRecipient(bmRequestTypeRecipient), .bRequest(bRequest),
      .wValue(wValue), .wIndex(wIndex), .wLength(wLength),
      .in_token(in_token), .out_token(out_token), .out_zlp(out_zlp), .tx_ack(tx_ack),
      .tx_req(tx_req), .tx_addr(tx_addr), .tx_len(tx_len), .tx_zero(tx_zero),
      .tx_data1(tx_data1), .stall(stall), .dev_addr(dev_addr), .configured(configured)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setupReq(input logic dir, input logic [1:0] typ, input logic [7:0] req,
                           input logic [15:0] val, input logic [15:0] len);
      bmRequestTypeDPTD = dir;
      bmRequestTypeType = typ;
      bRequest = req;
      wValue = val;
      wLength = len;
      setup_valid = 1'b1;
      tick();
      setup_valid = 1'b0;
      tick();
   endtask

   task automatic inTok();
      in_token = 1'b1;
      tick();
      in_token = 1'b0;
   endtask

   task automatic outTok();
      out_token = 1'b1;
      tick();
      out_token = 1'b0;
   endtask

   task automatic ackTx();
      tx_ack = 1'b1;
      tick();
      tx_ack = 1'b0;
   endtask

   task automatic zlpOut();
      out_zlp = 1'b1;
      tick();
      out_zlp = 1'b0;
   endtask

   task automatic expectPkt(input string tag, input bit chkAddr, input int addr, input int len,
                            input logic d1, input logic zero);
      checkVal({tag, "_req"}, tx_req, 1);
      if (chkAddr) checkVal({tag, "_addr"}, tx_addr, addr);
      checkVal({tag, "_len"}, tx_len, len);
      checkVal({tag, "_pid"}, tx_data1, d1);
      checkVal({tag, "_zero"}, tx_zero, zero);
      tick();
      checkVal({tag, "_pulse"}, tx_req, 0);
   endtask

   task automatic expectNoPkt(input string tag);
      inTok();
      checkVal(tag, tx_req, 0);
   endtask

   int devAddrTbl[3] = '{0, 8, 16};
   int devLenTbl[3]  = '{8, 8, 2};
   int devPidTbl[3]  = '{1, 0, 1};
   int cfgAddrTbl[4] = '{18, 26, 34, 42};

   initial begin
      // reset state, checked while reset is still low before any clock edge
      #2;
      checkVal("rst_req", tx_req, 0);
      checkVal("rst_addr", tx_addr, 0);
      checkVal("rst_len", tx_len, 0);
      checkVal("rst_zero", tx_zero, 0);
      checkVal("rst_pid", tx_data1, 0);
      checkVal("rst_stall", stall, 0);
      checkVal("rst_devaddr", dev_addr, 0);
      checkVal("rst_cfg", configured, 0);
      tick();
      reset = 1'b1;
      tick();

      // 1: device descriptor, wLength 64
      setupReq(1, 0, 8'h06, 16'h0100, 16'd64);
      for (int i = 0; i < 3; i++) begin
         inTok();
         expectPkt($sformatf("dev%0d", i), 1, devAddrTbl[i], devLenTbl[i], devPidTbl[i][0], 0);
         ackTx();
      end
      expectNoPkt("dev_nozlp");
      zlpOut();
      expectNoPkt("dev_idle");

      // 2: configuration descriptor, wLength 255 -> trailing ZLP
      setupReq(1, 0, 8'h06, 16'h0200, 16'd255);
      for (int i = 0; i < 4; i++) begin
         inTok();
         expectPkt($sformatf("cfg%0d", i), 1, cfgAddrTbl[i], 8, ~i[0], 0);
         ackTx();
      end
      inTok();
      expectPkt("cfg_zlp", 1, 50, 0, 1, 0);
      ackTx();
      expectNoPkt("cfg_after_zlp");
      zlpOut();

      // 2b: configuration descriptor, wLength 8 -> single packet
      setupReq(1, 0, 8'h06, 16'h0200, 16'd8);
      inTok();
      expectPkt("cfg8", 1, 18, 8, 1, 0);
      ackTx();
      expectNoPkt("cfg8_nozlp");
      zlpOut();

      // 3: SET_ADDRESS 0x23
      setupReq(0, 0, 8'h05, 16'h0023, 16'd0);
      checkVal("addr_pre", dev_addr, 0);
      inTok();
      expectPkt("addr_st", 0, 0, 0, 1, 0);
      checkVal("addr_mid", dev_addr, 0);
      inTok();
      expectPkt("addr_retry", 0, 0, 0, 1, 0);
      tx_ack = 1'b1;
      #1;
      checkVal("addr_at_ack", dev_addr, 0);
      tick();
      tx_ack = 1'b0;
      checkVal("addr_post", dev_addr, 7'h23);

      // 4: unsupported standard request and vendor request stall
      setupReq(0, 0, 8'h0C, 16'h0000, 16'd0);
      checkVal("stall_std", stall, 1);
      expectNoPkt("stall_in");
      outTok();
      checkVal("stall_out", stall, 1);
      setupReq(0, 2, 8'h05, 16'h0011, 16'd0);
      checkVal("stall_vendor", stall, 1);
      checkVal("stall_vendor_addr", dev_addr, 7'h23);
      bmRequestTypeDPTD = 1'b1;
      bmRequestTypeType = 2'd0;
      bRequest = 8'h00;
      wValue = 16'h0000;
      wLength = 16'd2;
      setup_valid = 1'b1;
      tick();
      setup_valid = 1'b0;
      checkVal("stall_clear", stall, 0);
      tick();
      inTok();
      expectPkt("getstat", 0, 0, 2, 1, 1);
      ackTx();
      expectNoPkt("getstat_done");
      zlpOut();

      // 4b: SET_ADDRESS out of range stalls, SET_CONFIGURATION(1) applies on ack
      setupReq(0, 0, 8'h05, 16'd200, 16'd0);
      checkVal("addr200_stall", stall, 1);
      setupReq(0, 0, 8'h09, 16'h0001, 16'd0);
      checkVal("setcfg_stall", stall, 0);
      inTok();
      expectPkt("setcfg_st", 0, 0, 0, 1, 0);
      checkVal("setcfg_pre", configured, 0);
      ackTx();
      checkVal("setcfg_post", configured, 1);
      checkVal("setcfg_addr_kept", dev_addr, 7'h23);

      // 5: retry without ack, then early abort via OUT
      setupReq(1, 0, 8'h06, 16'h0100, 16'd64);
      inTok();
      expectPkt("retry_a", 1, 0, 8, 1, 0);
      inTok();
      expectPkt("retry_b", 1, 0, 8, 1, 0);
      ackTx();
      outTok();
      expectNoPkt("abort_in");
      zlpOut();

      // 5b: GET_DESCRIPTOR with wLength 0 goes straight to status IN
      setupReq(1, 0, 8'h06, 16'h0100, 16'd0);
      inTok();
      expectPkt("wlen0_st", 0, 0, 0, 1, 0);
      ackTx();
      expectNoPkt("wlen0_idle");

      // 6: setup coincident with ack wins, then async reset mid-WAIT_ACK
      setupReq(1, 0, 8'h06, 16'h0100, 16'd64);
      inTok();
      expectPkt("coin_a", 1, 0, 8, 1, 0);
      ackTx();
      inTok();
      expectPkt("coin_b", 1, 8, 8, 0, 0);
      bmRequestTypeDPTD = 1'b1;
      bmRequestTypeType = 2'd0;
      bRequest = 8'h06;
      wValue = 16'h0200;
      wLength = 16'd255;
      setup_valid = 1'b1;
      tx_ack = 1'b1;
      tick();
      setup_valid = 1'b0;
      tx_ack = 1'b0;
      tick();
      inTok();
      expectPkt("coin_new", 1, 18, 8, 1, 0);
      #2;
      reset = 1'b0;
      #1;
      checkVal("arst_req", tx_req, 0);
      checkVal("arst_addr", tx_addr, 0);
      checkVal("arst_len", tx_len, 0);
      checkVal("arst_pid", tx_data1, 0);
      checkVal("arst_devaddr", dev_addr, 0);
      checkVal("arst_cfg", configured, 0);
      checkVal("arst_stall", stall, 0);
      #2;
      reset = 1'b1;
      tick();
      expectNoPkt("arst_idle");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

endmodule

// File: doc/ep0_ctrl_handler.md
Name: ep0_ctrl_handler

Overview:
Endpoint-0 control-transfer engine that sits directly downstream of the setup-packet buffer. It takes the decoded 8-byte SETUP fields and a completion strobe, then decodes the standard request. It sequences the data and status stages against IN/OUT token and handshake strobes from the packet layer. It drives the transmit packetiser with descriptor-ROM chunk requests and owns the device address and configured state.

Parameters:
MAX_PKT, 8, EP0 max packet size in bytes (8/16/32/64)
ROM_AW, 8, descriptor ROM address width
DEV_DESC_ADDR, 0, ROM offset of device descriptor
DEV_DESC_LEN, 18, device descriptor length
CFG_DESC_ADDR, 18, ROM offset of configuration descriptor (full hierarchy)
CFG_DESC_LEN, 32, total configuration descriptor length

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
setup_valid  in  1  one-cycle pulse: SETUP DATA0 received and ACKed, fields stable
bmRequestTypeDPTD  in  1  direction (1 = device-to-host)
bmRequestTypeType  in  2  0 = standard
bmRequestTypeRecipient  in  5  recipient
bRequest  in  8  request code
wValue  in  16  request value
wIndex  in  16  request index (unused; ignored)
wLength  in  16  host-requested length
in_token  in  1  pulse: IN token to EP0 at current address
out_token  in  1  pulse: OUT token to EP0
out_zlp  in  1  pulse: zero-length DATA1 OUT received and ACKed
tx_ack  in  1  pulse: host ACKed last transmitted packet
tx_req  out  1  pulse: send one data packet
tx_addr  out  ROM_AW  ROM start address of chunk
tx_len  out  7  chunk length, 0..MAX_PKT
tx_zero  out  1  source is constant zero bytes, not ROM
tx_data1  out  1  PID: 1 = DATA1, 0 = DATA0
stall  out  1  packet layer answers EP0 tokens with STALL
dev_addr  out  7  active USB address
configured  out  1  SET_CONFIGURATION(1) applied

Behaviour:
- Reset (reset low, asynchronous): state IDLE; tx_req, tx_addr, tx_len, tx_zero, tx_data1, stall, dev_addr and configured all 0; internal ptr, remaining, need_zlp and pending registers cleared.
- States: IDLE, DECODE, DATA_IN, WAIT_ACK, STATUS_OUT, STATUS_IN, STATUS_WAIT, STALL.
- setup_valid from any state, same cycle: -> DECODE; stall cleared; toggle set to DATA1. SETUP has priority over any simultaneous token or ack.
- DECODE (exactly 1 cycle). A non-standard Type (!=0) -> STALL. Standard requests:
  - GET_DESCRIPTOR (0x06, DPTD=1), wValue[15:8]=1 device / 2 config:
    - len = desc length; remaining = min(wLength, len); ptr = base.
    - need_zlp = (len < wLength) && (len % MAX_PKT == 0).
    - -> DATA_IN, or -> STATUS_IN if wLength = 0.
    - Any other descriptor type -> STALL.
  - GET_STATUS (0x00, DPTD=1): tx_zero source; remaining = min(wLength, 2); need_zlp = 0; -> DATA_IN (STATUS_IN if wLength = 0).
  - SET_ADDRESS (0x05, DPTD=0, wValue <= 127): pend_addr = wValue[6:0] -> STATUS_IN. wValue > 127 -> STALL.
  - SET_CONFIGURATION (0x09, DPTD=0, wValue[7:0] in {0,1}): pend_cfg latched -> STATUS_IN. Other values -> STALL.
  - Anything else -> STALL.
- DATA_IN, in_token:
  - If remaining > 0 or need_zlp: one-cycle tx_req with tx_addr = ptr, tx_len = min(remaining, MAX_PKT), tx_data1 = toggle -> WAIT_ACK.
  - Otherwise -> STATUS_OUT.
- WAIT_ACK:
  - tx_ack: ptr += tx_len, remaining -= tx_len, toggle flips; if tx_len = 0, clear need_zlp.
  - Then -> DATA_IN if remaining > 0 or need_zlp, else STATUS_OUT.
  - in_token without prior tx_ack is a retry: re-issue tx_req with identical addr, len and PID; no advance.
- out_token in DATA_IN or WAIT_ACK: host aborted the data stage early -> STATUS_OUT.
- STATUS_OUT: out_zlp -> IDLE. in_token ignored.
- STATUS_IN: in_token -> tx_req with tx_len = 0, tx_data1 = 1 -> STATUS_WAIT.
- STATUS_WAIT:
  - tx_ack: dev_addr <= pend_addr (SET_ADDRESS only), configured <= pend_cfg (SET_CONFIGURATION only); -> IDLE.
  - in_token retries the ZLP.
  - dev_addr must not change before this ack.
- STALL: stall = 1; all tokens ignored; exit only via setup_valid.
- IDLE: tokens ignored.
- Arithmetic: remaining is 16 bits. ptr wraps modulo 2^ROM_AW; ROM layout is the integrator's responsibility.

Test Plan:
1. GET_DESCRIPTOR device, wLength=64, MAX_PKT=8, each IN acked -> tx_req (addr,len,PID): (0,8,D1), (8,8,D0), (16,2,D1); no ZLP; out_zlp -> IDLE.
2. GET_DESCRIPTOR config, wLength=255, CFG_DESC_LEN=32 -> four 8-byte packets at 18, 26, 34, 42 with alternating PID from D1, then ZLP with D1; wLength=8 -> single packet, no ZLP.
3. SET_ADDRESS wValue=0x23 -> dev_addr=0 through status tx_req (len 0, D1); becomes 0x23 the cycle after tx_ack.
4. bRequest=0x0C standard, then Type=2 vendor request -> stall=1, IN/OUT ignored; next setup_valid with GET_STATUS wLength=2 -> stall=0, tx_req tx_zero=1 len 2 D1.
5. IN, no tx_ack, IN again mid-descriptor -> identical tx_addr/tx_len/tx_data1; early out_token during DATA_IN -> STATUS_OUT.
6. reset low mid-WAIT_ACK, and setup_valid coincident with tx_ack -> all outputs 0 immediately without a clock edge; DECODE wins and ptr does not advance.
